// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry, write-record types and word-address helper
package fb_pkg;
   localparam int FB_WIDTH       = 640;
   localparam int FB_HEIGHT      = 480;
   localparam int WORDS_PER_LINE = 160;
   localparam int ADDR_W         = 17;
   typedef logic [ADDR_W-1:0] fb_addr_t;
   typedef logic [15:0]       fb_word_t;
   typedef struct packed {
      fb_addr_t   addr;
      fb_word_t   data;
      logic [3:0] nib_en;
   } fb_wr_t;
   typedef enum logic [1:0] {ACCUM, FLUSH_PUSH, FLUSH_DRAIN} fb_state_t;
   // y*WORDS_PER_LINE + x/4 using shifts only; meaningful for in-range pixels
   function automatic fb_addr_t word_addr(input logic [9:0] x, input logic [9:0] y);
      return (fb_addr_t'(y) << 7) + (fb_addr_t'(y) << 5) + fb_addr_t'(x[9:2]);
   endfunction
endpackage

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo: show-ahead FIFO of framebuffer word writes
//  clk, areset_n : clock, async active-low reset
//  push, wdata   : enqueue (ignored when full)
//  pop           : dequeue head (ignored when empty)
//  rdata         : current head, valid while !empty
//  count, full, empty : occupancy
module fb_wr_fifo
   import fb_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   areset_n,
   input  logic                   push,
   input  fb_wr_t                 wdata,
   input  logic                   pop,
   output fb_wr_t                 rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int PW = $clog2(DEPTH);
   fb_wr_t mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign full    = count == (PW+1)'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) mem[wr_ptr] <= wdata;
         wr_ptr <= wr_ptr + PW'(do_push);
         rd_ptr <= rd_ptr + PW'(do_pop);
         count  <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/fb_write_coalescer.sv
// fb_write_coalescer: packs 4bpp pixel writes into nibble-masked 16-bit framebuffer word writes
//  clk, areset_n        : clock, async active-low reset
//  pix_valid/ready, pix_x, pix_y, pix_data : pixel write stream from the rasterizer
//  flush, flush_done    : drain request pulse and completion pulse
//  busy, drop_count     : activity flag and saturating out-of-range pixel count
//  mem_req/ack, mem_addr, mem_data, mem_nib_en : word write port (may stall)
module fb_write_coalescer
   import fb_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              areset_n,
   input  logic              pix_valid,
   output logic              pix_ready,
   input  logic [9:0]        pix_x,
   input  logic [9:0]        pix_y,
   input  logic [3:0]        pix_data,
   input  logic              flush,
   output logic              flush_done,
   output logic              busy,
   output logic [15:0]       drop_count,
   output logic              mem_req,
   input  logic              mem_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_data,
   output logic [3:0]        mem_nib_en
);
   fb_state_t state, state_nxt;
   fb_wr_t acc, head;
   logic acc_valid, push, fifo_full, fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic in_range, accept, take, same;
   fb_addr_t addr;
   fb_word_t pix_word, nib_mask;
   logic [3:0] nib_sel;
   assign in_range  = pix_x < 10'(FB_WIDTH) && pix_y < 10'(FB_HEIGHT);
   assign addr      = word_addr(pix_x, pix_y);
   assign nib_sel   = 4'b0001 << pix_x[1:0];
   assign nib_mask  = 16'h000F << {pix_x[1:0], 2'b00};
   assign pix_word  = fb_word_t'(pix_data) << {pix_x[1:0], 2'b00};
   assign pix_ready = state == ACCUM && !flush && !fifo_full;
   assign accept    = pix_valid && pix_ready;
   assign take      = accept && in_range;
   assign same      = acc_valid && acc.addr == addr;
   assign busy      = acc_valid || !fifo_empty || state != ACCUM;
   assign mem_req    = !fifo_empty;
   assign mem_addr   = head.addr;
   assign mem_data   = head.data;
   assign mem_nib_en = head.nib_en;
   always_comb begin
      state_nxt  = state;
      push       = 1'b0;
      flush_done = 1'b0;
      case (state)
         ACCUM: begin
            push = take && acc_valid && !same;
            if (flush) state_nxt = FLUSH_PUSH;
         end
         FLUSH_PUSH: begin
            // hold here only while a valid accumulator waits for a free slot
            push = acc_valid && !fifo_full;
            if (!acc_valid || !fifo_full) state_nxt = FLUSH_DRAIN;
         end
         FLUSH_DRAIN: begin
            flush_done = fifo_empty;
            if (fifo_empty) state_nxt = ACCUM;
         end
         default: state_nxt = ACCUM;
      endcase
   end
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) state <= ACCUM;
      else state <= state_nxt;
   end
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         acc        <= '0;
         acc_valid  <= 1'b0;
         drop_count <= '0;
      end else begin
         if (take) begin
            acc.addr   <= addr;
            acc.data   <= same ? (acc.data & ~nib_mask) | pix_word : pix_word;
            acc.nib_en <= same ? acc.nib_en | nib_sel : nib_sel;
            acc_valid  <= 1'b1;
         end else if (state == FLUSH_PUSH && push) acc_valid <= 1'b0;
         if (accept && !in_range && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
   end
   fb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .areset_n(areset_n), .push(push), .wdata(acc), .pop(mem_ack),
      .rdata(head), .count(fifo_count), .full(fifo_full), .empty(fifo_empty)
   );
endmodule

// File: tb/tb_fb_write_coalescer.sv
// tb_fb_write_coalescer: randomized and directed bench with a pixel-level reference model
module tb_fb_write_coalescer;
   logic clk = 0, areset_n = 0, pix_valid = 0, flush = 0, mem_ack = 0;
   logic [9:0] pix_x = 0, pix_y = 0;
   logic [3:0] pix_data = 0;
   logic pix_ready, flush_done, busy, mem_req;
   logic [15:0] drop_count, mem_data;
   logic [16:0] mem_addr;
   logic [3:0] mem_nib_en;
   fb_write_coalescer dut (
      .clk(clk), .areset_n(areset_n), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data), .flush(flush), .flush_done(flush_done),
      .busy(busy), .drop_count(drop_count), .mem_req(mem_req), .mem_ack(mem_ack),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_nib_en(mem_nib_en)
   );
   always #5 clk = ~clk;
   typedef struct {int addr; logic [15:0] data; logic [3:0] m;} wr_t;
   int total = 0, bad = 0;
   bit rand_ack = 0;
   wr_t q[$];
   bit m_acc = 0, m_flushing = 0, hold = 0;
   int m_word = 0, m_drop = 0, nwrites = 0, ndone = 0;
   logic [3:0] m_nib [4];
   logic [3:0] m_mask = 0;
   wr_t last, held;
   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic wr_t acc_word();
      wr_t w;
      w.addr = m_word; w.m = m_mask; w.data = 0;
      for (int k = 0; k < 4; k++) if (m_mask[k]) w.data[4*k +: 4] = m_nib[k];
      return w;
   endfunction
   // reference: a word is emitted when a pixel for another word arrives or on flush
   task automatic m_pixel(input int x, input int y, input logic [3:0] d);
      int w;
      if (x >= 640 || y >= 480) begin
         if (m_drop < 65535) m_drop++;
      end else begin
         w = y * 160 + x / 4;
         if (!(m_acc && w == m_word)) begin
            if (m_acc) q.push_back(acc_word());
            m_acc = 1; m_word = w; m_mask = 0;
         end
         m_nib[x % 4] = d;
         m_mask[x % 4] = 1'b1;
      end
   endtask
   always @(negedge clk) begin
      wr_t e;
      if (!areset_n) begin
         q.delete(); m_acc = 0; m_flushing = 0; m_drop = 0; hold = 0; m_mask = 0;
      end else begin
         chk("drop_count", drop_count, m_drop);
         chk("busy", busy, m_acc || q.size() != 0 || m_flushing);
         chk("mem_req_spurious", mem_req && q.size() == 0, 0);
         if (hold) begin
            chk("req_held", mem_req, 1);
            chk("stable_addr", mem_addr, held.addr);
            chk("stable_data", mem_data, held.data);
            chk("stable_nib", mem_nib_en, held.m);
         end
         hold = mem_req && !mem_ack;
         held.addr = mem_addr; held.data = mem_data; held.m = mem_nib_en;
         if (mem_req && mem_ack && q.size() != 0) begin
            e = q.pop_front();
            chk("wr_addr", mem_addr, e.addr);
            chk("wr_data", mem_data, e.data);
            chk("wr_nib_en", mem_nib_en, e.m);
            last.addr = mem_addr; last.data = mem_data; last.m = mem_nib_en;
            nwrites++;
         end
         if (pix_valid && pix_ready) m_pixel(int'(pix_x), int'(pix_y), pix_data);
         if (flush && !m_flushing) begin
            if (m_acc) q.push_back(acc_word());
            m_acc = 0; m_flushing = 1;
         end
         if (flush_done) begin
            chk("done_when_drained", q.size() == 0 && !m_acc && m_flushing, 1);
            m_flushing = 0;
            ndone++;
         end
      end
   end
   task automatic tick();
      @(posedge clk); #1;
      if (rand_ack) mem_ack = $urandom_range(0, 3) != 0;
   endtask
   task automatic send(input int x, input int y, input logic [3:0] d);
      bit ok = 0;
      pix_x = 10'(x); pix_y = 10'(y); pix_data = d; pix_valid = 1;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk); ok = pix_ready;
         tick();
      end
      pix_valid = 0;
      chk("send_accepted", ok, 1);
   endtask
   task automatic do_flush();
      bit got = 0;
      flush = 1; tick(); flush = 0;
      for (int i = 0; i < 3000 && !got; i++) begin
         @(negedge clk); got = flush_done;
         tick();
      end
      chk("flush_done_seen", got, 1);
   endtask
   initial begin
      #900000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end
   initial begin
      int n0, d0, x, y;
      bit ok;
      #1;
      chk("rst_pix_ready", pix_ready, 1);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_flush_done", flush_done, 0);
      chk("rst_drop", drop_count, 0);
      chk("rst_fields", {mem_addr, mem_data, mem_nib_en}, 0);
      repeat (2) @(posedge clk);
      #1 areset_n = 1; mem_ack = 1;
      tick();
      // one full word
      n0 = nwrites;
      for (int i = 0; i < 4; i++) send(i, 0, 4'(i + 1));
      do_flush();
      chk("t1_writes", nwrites - n0, 1);
      chk("t1_addr", last.addr, 0);
      chk("t1_data", last.data, 16'h4321);
      chk("t1_nib", last.m, 4'hF);
      // out-of-range pixel does not disturb the accumulator
      n0 = nwrites;
      send(5, 1, 4'hA); send(640, 0, 4'h3);
      do_flush();
      chk("t2_writes", nwrites - n0, 1);
      chk("t2_addr", last.addr, 161);
      chk("t2_data", last.data, 16'h00A0);
      chk("t2_nib", last.m, 4'b0010);
      chk("t2_drop", drop_count, 1);
      // repeated nibble overwrite and last framebuffer word
      n0 = nwrites;
      send(3, 2, 4'h5); send(3, 2, 4'h7);
      do_flush();
      chk("t3_writes", nwrites - n0, 1);
      chk("t3_addr", last.addr, 320);
      chk("t3_data", last.data, 16'h7000);
      chk("t3_nib", last.m, 4'b1000);
      send(639, 479, 4'h9);
      do_flush();
      chk("t3_corner_addr", last.addr, 76799);
      chk("t3_corner_data", last.data, 16'h9000);
      // full FIFO back-pressure
      mem_ack = 0; n0 = nwrites;
      for (int i = 0; i < 9; i++) send(i * 4, 10, 4'(i + 1));
      pix_x = 10'd36; pix_y = 10'd10; pix_data = 4'hA; pix_valid = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); chk("t4_full_stall", pix_ready, 0);
         tick();
      end
      mem_ack = 1; ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk); ok = pix_ready;
         tick();
      end
      pix_valid = 0;
      chk("t4_stall_clears", ok, 1);
      repeat (15) tick();
      chk("t4_writes", nwrites - n0, 9);
      do_flush();
      chk("t4_total", nwrites - n0, 10);
      // reset mid-operation
      mem_ack = 0;
      send(700, 0, 4'h1);
      for (int i = 0; i < 4; i++) send(i * 4, 20, 4'(i + 2));
      chk("t5_req_before", mem_req, 1);
      areset_n = 0;
      #1;
      chk("t5_req_dropped", mem_req, 0);
      chk("t5_drop_cleared", drop_count, 0);
      chk("t5_busy", busy, 0);
      chk("t5_ready", pix_ready, 1);
      tick(); tick();
      areset_n = 1; mem_ack = 1; n0 = nwrites;
      repeat (10) tick();
      chk("t5_no_write", nwrites - n0, 0);
      // empty flush timing
      flush = 1;
      @(negedge clk); chk("t6_done_n", flush_done, 0);
      tick(); flush = 0;
      @(negedge clk); chk("t6_done_n1", flush_done, 0);
      tick();
      @(negedge clk); chk("t6_done_n2", flush_done, 1);
      tick();
      @(negedge clk); chk("t6_done_n3", flush_done, 0);
      tick();
      // flush during drain is ignored
      mem_ack = 0;
      send(0, 30, 4'h1); send(4, 30, 4'h2);
      d0 = ndone;
      flush = 1; tick(); flush = 0;
      tick(); tick();
      flush = 1; tick(); flush = 0;
      mem_ack = 1; ok = 0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk); ok = flush_done;
         tick();
      end
      chk("t6_drain_done", ok, 1);
      repeat (6) tick();
      chk("t6_single_done", ndone - d0, 1);
      chk("t6_idle", busy, 0);
      // randomized traffic against the model
      rand_ack = 1;
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(0, 24) == 0) do_flush();
         else begin
            x = $urandom_range(624, 647);
            y = ($urandom_range(0, 7) == 0) ? $urandom_range(478, 481) : $urandom_range(0, 2);
            send(x, y, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) tick();
         end
      end
      do_flush();
      rand_ack = 0; mem_ack = 1;
      repeat (4) tick();
      chk("end_queue_empty", q.size(), 0);
      chk("end_busy", busy, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
